bp_lookup_resolve: RTL and testbench
====================================

// Module: bp_lookup_resolve
// PURPOSE
//  Read side of the 1024-entry branch prediction table. At fetch, indexes the table
//  with PC[11:2] and produces a predicted next PC. Buffers in-flight predictions
//  in order. At branch resolution, compares the actual outcome against the
//  buffered prediction and raises mispredict/redirect.
//  Emits the isBranch/isTaken/InstrPC update triple that trains the table.
// PARAMETERS
//  DEPTH      4    in-flight branch entries; must be a power of 2, >= 2
//  IDX_W      10   table index width (index = pc[IDX_W+1:2])
// PORTS
//  CLK            in   1   clock; all state changes on posedge
//  RESET          in   1   synchronous, active-low reset
//  fetch_valid    in   1   fetch stage presents an instruction this cycle
//  fetch_pc       in   32  PC of the fetched instruction
//  fetch_is_br    in   1   fetched instruction is a conditional branch
//  fetch_target   in   32  decoded taken-target of the branch
//  fetch_ready    out  1   entry buffer can accept a branch (!full)
//  tbl_idx        out  IDX_W  prediction table read index (combinational)
//  tbl_pred       in   1   Pred[tbl_idx] returned by the table (combinational)
//  pred_taken     out  1   prediction for the current fetch (combinational)
//  next_pc        out  32  pred_taken ? fetch_target : fetch_pc+4 (combinational)
//  res_valid      in   1   oldest in-flight branch resolves this cycle
//  res_taken      in   1   actual direction of the resolving branch
//  res_target     in   32  actual taken-target of the resolving branch
//  mispredict     out  1   registered 1-cycle pulse: prediction was wrong
//  redirect_pc    out  32  registered correct PC, valid with mispredict
//  upd_isBranch   out  1   registered 1-cycle pulse to table isBranch
//  upd_isTaken    out  1   registered actual direction to table isTaken
//  upd_InstrPC    out  32  registered PC of the resolved branch to table InstrPC
//  err_underflow  out  1   sticky: res_valid seen while buffer empty
// BEHAVIOUR
//  Reset (RESET=0 at posedge): head=tail=count=0. All registered outputs 0.
//   err_underflow is cleared. Entries are not cleared (count gates validity).
//  Lookup, 0 latency: tbl_idx=fetch_pc[IDX_W+1:2].
//   pred_taken=fetch_valid&fetch_is_br&tbl_pred.
//   next_pc follows pred_taken; fetch_pc+4 wraps modulo 2^32.
//  Enqueue: push occurs when fetch_valid & fetch_is_br & fetch_ready & !kill.
//   Entry = {pc, pred_taken}. Non-branches are never buffered.
//  fetch_ready=(count!=DEPTH). There is no pop-bypass: when the buffer is full
//   and a resolve arrives in the same cycle, the push is still refused.
//  Resolve: res_valid & count!=0 pops the head. Registered next cycle:
//   upd_isBranch=1, upd_isTaken=res_taken, upd_InstrPC=head.pc.
//   mispredict=(res_taken!=head.pred).
//   redirect_pc=res_taken ? res_target : head.pc+4.
//   All pulses are held for exactly 1 cycle, then return to 0.
//  kill=res_valid & count!=0 & (res_taken!=head.pred), evaluated combinationally.
//   On kill, the buffer empties at that edge (head=tail, count=0): younger
//   entries are wrong-path. A same-cycle push is discarded.
//  res_valid & count==0: no pop and no update pulse; err_underflow<=1 (sticky
//   until reset).
//  Simultaneous push+pop without kill: count is unchanged; both pointers advance.
//  Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//  Reset asserted mid-operation discards all in-flight entries and any pending
//   pulses.
// STRUCTURE
//  Shared package bp_pkg: IDX_W, PC_W=32, and the typedef bp_entry_t {pc, pred}.
//  One sub-module bp_inflight_fifo holds the FIFO pointers, count, and storage,
//   with push, pop, and flush inputs. This top wraps it with the lookup and
//   compare logic.
// TESTING
//  1 Reset, then fetch pc=0x100 br, tbl_pred=1, target=0x200
//    -> tbl_idx=0x040, pred_taken=1, next_pc=0x200.
//  2 Non-branch at pc=0x104 -> next_pc=0x108, count unchanged.
//  3 Push pred=1; resolve res_taken=1 -> next cycle upd_isBranch=1,
//    upd_isTaken=1, upd_InstrPC=0x100, mispredict=0.
//  4 Push pcs 0x10,0x20,0x30 pred=0; resolve head taken, res_target=0x80
//    -> mispredict=1, redirect_pc=0x80, count=0; a push in the same cycle
//    is dropped.
//  5 Fill with 4 entries -> fetch_ready=0; resolve+push in the same cycle
//    -> push refused, count=3.
//  6 res_valid with empty buffer -> no upd pulse, err_underflow=1 until RESET=0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction read/resolve path.
package bp_pkg;

    localparam int unsigned IDX_W = 10;
    localparam int unsigned PC_W  = 32;

    // One in-flight branch: its PC and the direction predicted at fetch.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order buffer of in-flight branch predictions with push, pop and flush.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  bp_entry_t wdata_i,
    output bp_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    bp_entry_t        mem_q [DEPTH];
    bp_entry_t        mem_d [DEPTH];
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[head_q];

    // Never overrun or underrun, even if the caller forgets to gate.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next-state for pointers, occupancy and storage; flush wins over everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush_i) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[tail_q] = wdata_i;
                tail_d        = tail_q + 1'b1;
            end
            if (pop_ok) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
        end
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bp_lookup_resolve.sv
// Branch prediction lookup at fetch and outcome check at resolve.
module bp_lookup_resolve
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = bp_pkg::IDX_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    input  logic             fetch_is_br,
    input  logic [31:0]      fetch_target,
    output logic             fetch_ready,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic             tbl_pred,
    output logic             pred_taken,
    output logic [31:0]      next_pc,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             upd_isBranch,
    output logic             upd_isTaken,
    output logic [31:0]      upd_InstrPC,
    output logic             err_underflow
);

    bp_entry_t   head, wdata;
    logic        full, empty;
    logic        pop, kill, push;

    logic        mispredict_q, mispredict_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        upd_isBranch_q, upd_isBranch_d;
    logic        upd_isTaken_q, upd_isTaken_d;
    logic [31:0] upd_InstrPC_q, upd_InstrPC_d;
    logic        err_underflow_q, err_underflow_d;

    // Zero-latency lookup and next-PC selection.
    always_comb begin
        tbl_idx    = fetch_pc[IDX_W+1:2];
        pred_taken = fetch_valid & fetch_is_br & tbl_pred;
        next_pc    = pred_taken ? fetch_target : fetch_pc + 32'd4;
    end

    assign fetch_ready = ~full;
    assign pop         = res_valid & ~empty;
    // A wrong head prediction makes every younger entry wrong-path.
    assign kill        = pop & (res_taken != head.pred);
    assign push        = fetch_valid & fetch_is_br & fetch_ready & ~kill;
    assign wdata       = '{pc: fetch_pc, pred: pred_taken};

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (kill),
        .wdata_i (wdata),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Resolve outputs: single-cycle pulses, zero when nothing resolved.
    always_comb begin
        mispredict_d    = kill;
        redirect_pc_d   = '0;
        upd_isBranch_d  = pop;
        upd_isTaken_d   = pop & res_taken;
        upd_InstrPC_d   = pop ? head.pc : '0;
        err_underflow_d = err_underflow_q | (res_valid & empty);
        if (kill) begin
            redirect_pc_d = res_taken ? res_target : head.pc + 32'd4;
        end
    end

    // Registered resolve outputs with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            upd_isBranch_q  <= 1'b0;
            upd_isTaken_q   <= 1'b0;
            upd_InstrPC_q   <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            mispredict_q    <= mispredict_d;
            redirect_pc_q   <= redirect_pc_d;
            upd_isBranch_q  <= upd_isBranch_d;
            upd_isTaken_q   <= upd_isTaken_d;
            upd_InstrPC_q   <= upd_InstrPC_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign upd_isBranch  = upd_isBranch_q;
    assign upd_isTaken   = upd_isTaken_q;
    assign upd_InstrPC   = upd_InstrPC_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_bp_lookup_resolve.sv
// Self-checking bench: lookup vector table, directed sequences, random run vs queue model.
module tb_bp_lookup_resolve;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDX_W = 10;

    logic             clk;
    logic             rst_n;
    logic             fetch_valid, fetch_is_br, fetch_ready, tbl_pred, pred_taken;
    logic [31:0]      fetch_pc, fetch_target, next_pc;
    logic [IDX_W-1:0] tbl_idx;
    logic             res_valid, res_taken, mispredict;
    logic [31:0]      res_target, redirect_pc;
    logic             upd_isBranch, upd_isTaken, err_underflow;
    logic [31:0]      upd_InstrPC;

    bp_lookup_resolve #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_is_br   (fetch_is_br),
        .fetch_target  (fetch_target),
        .fetch_ready   (fetch_ready),
        .tbl_idx       (tbl_idx),
        .tbl_pred      (tbl_pred),
        .pred_taken    (pred_taken),
        .next_pc       (next_pc),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .upd_isBranch  (upd_isBranch),
        .upd_isTaken   (upd_isTaken),
        .upd_InstrPC   (upd_InstrPC),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: in-flight branches as a plain queue.
    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } ent_t;
    ent_t q[$];
    logic model_valid = 1'b0;
    logic m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; checks lookup outputs before the edge, resolve outputs after.
    task automatic step(input logic fv, input logic br, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic tp, input logic rv,
                        input logic rt, input logic [31:0] rtg, input logic rst);
        logic        e_pt, pop, mis, push;
        logic [31:0] e_np, e_redir;
        ent_t        h;
        @(negedge clk);
        fetch_valid = fv; fetch_is_br = br; fetch_pc = pc; fetch_target = tgt;
        tbl_pred = tp; res_valid = rv; res_taken = rt; res_target = rtg; rst_n = rst;
        #1;
        e_pt = fv & br & tp;
        e_np = e_pt ? tgt : pc + 32'd4;
        chk("tbl_idx", 32'(tbl_idx), (pc >> 2) & 32'h3ff);
        chk("pred_taken", 32'(pred_taken), 32'(e_pt));
        chk("next_pc", next_pc, e_np);
        if (model_valid) chk("fetch_ready", 32'(fetch_ready), 32'(q.size() != DEPTH));
        pop     = rv && (q.size() != 0);
        h       = pop ? q[0] : '0;
        mis     = pop && (rt != h.pred);
        push    = fv && br && (q.size() != DEPTH) && !mis;
        e_redir = rt ? rtg : h.pc + 32'd4;
        @(posedge clk);
        #1;
        if (!rst) begin
            q.delete();
            m_err = 1'b0;
            pop = 1'b0;
            mis = 1'b0;
            model_valid = 1'b1;
        end else begin
            if (rv && q.size() == 0) m_err = 1'b1;
            if (mis) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{pc: pc, pred: e_pt});
            end
        end
        chk("upd_isBranch", 32'(upd_isBranch), 32'(pop));
        chk("mispredict", 32'(mispredict), 32'(mis));
        chk("err_underflow", 32'(err_underflow), 32'(m_err));
        if (pop) begin
            chk("upd_isTaken", 32'(upd_isTaken), 32'(rt));
            chk("upd_InstrPC", upd_InstrPC, h.pc);
        end
        if (mis) chk("redirect_pc", redirect_pc, e_redir);
    endtask

    typedef struct {
        logic        fv, br, tp;
        logic [31:0] pc, tgt;
        logic [9:0]  e_idx;
        logic        e_pt;
        logic [31:0] e_np;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{1, 1, 1, 32'h100, 32'h200, 10'h040, 1, 32'h200};
        vecs[1] = '{1, 0, 1, 32'h104, 32'h200, 10'h041, 0, 32'h108};
        vecs[2] = '{1, 1, 0, 32'hFFFF_FFFC, 32'h40, 10'h3FF, 0, 32'h0};
        vecs[3] = '{0, 1, 1, 32'h1000, 32'h300, 10'h000, 0, 32'h1004};
        vecs[4] = '{1, 1, 1, 32'hABC, 32'h5000, 10'h2AF, 1, 32'h5000};
        vecs[5] = '{1, 1, 0, 32'h7FC, 32'h10, 10'h1FF, 0, 32'h800};

        rst_n = 1'b0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        // Lookup is combinational; hold reset so pushes cannot take effect.
        for (int i = 0; i < 6; i++) begin
            fetch_valid = vecs[i].fv; fetch_is_br = vecs[i].br; tbl_pred = vecs[i].tp;
            fetch_pc = vecs[i].pc; fetch_target = vecs[i].tgt;
            #2;
            chk("vec_idx", 32'(tbl_idx), 32'(vecs[i].e_idx));
            chk("vec_pred", 32'(pred_taken), 32'(vecs[i].e_pt));
            chk("vec_next", next_pc, vecs[i].e_np);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);

        // 1..3: predicted-taken branch, non-branch, correct resolve.
        step(1, 1, 32'h100, 32'h200, 1, 0, 0, 0, 1);
        step(1, 0, 32'h104, 32'h0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1, 32'h200, 1);
        chk("t3_upd_pc", upd_InstrPC, 32'h100);

        // 4: mispredict on head flushes; same-cycle push dropped, so next resolve underflows.
        step(1, 1, 32'h10, 32'h90, 0, 0, 0, 0, 1);
        step(1, 1, 32'h20, 32'h90, 0, 0, 0, 0, 1);
        step(1, 1, 32'h30, 32'h90, 0, 0, 0, 0, 1);
        step(1, 1, 32'h40, 32'h90, 0, 1, 1, 32'h80, 1);
        chk("t4_redirect", redirect_pc, 32'h80);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        chk("t4_flushed", 32'(err_underflow), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 5: full buffer refuses push even while resolving.
        for (int i = 0; i < 4; i++) step(1, 1, 32'h400 + 32'(i) * 4, 32'h900, 1, 0, 0, 0, 1);
        #1 chk("t5_full", 32'(fetch_ready), 32'd0);
        step(1, 1, 32'h500, 32'h900, 1, 1, 1, 32'h900, 1);
        step(1, 1, 32'h504, 32'h900, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1, 32'h900, 1);

        // 6: resolve with empty buffer sets sticky error, reset clears it.
        step(0, 0, 0, 0, 0, 1, 1, 32'h0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_sticky", 32'(err_underflow), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_cleared", 32'(err_underflow), 32'd0);

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom,
                 $urandom, 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
                 $urandom, $urandom_range(0, 79) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
